// File: rtl/i2c_gain_writer.sv
// Single-master I2C write engine: one start pulse sends address+W, a register
// pointer and the three 6-bit PID gains to the gain-configuration slave.
module i2c_gain_writer #(
  parameter int         CLK_DIV    = 4,
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter logic [7:0] REG_BASE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic [5:0] K_p,
  input  logic [5:0] K_i,
  input  logic [5:0] K_d,
  input  logic       SCL_in,
  output logic       SCL_out,
  output logic       SCL_ena,
  input  logic       SDA_in,
  output logic       SDA_out,
  output logic       SDA_ena,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [2:0] dbg_state
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_SHIFT, ST_ACK, ST_STOP} state_t;

  state_t          state;
  logic [1:0]      quarter;
  logic [DW-1:0]   div;
  logic [39:0]     sh;
  logic [2:0]      bit_idx;
  logic [2:0]      byte_idx;

  logic div_end;
  logic stretched;
  logic q_end;

  // Handshake: start is a request that is taken only on a cycle where ena=1
  // and busy=0; busy stays high until the cycle done pulses.
  assign div_end   = (div == DIV_LAST);
  // A slave holding SCL low in q2 parks the divider on its last count.
  assign stretched = (quarter == 2'd2) && !SCL_in;
  assign q_end     = div_end && !stretched;

  assign SCL_out   = 1'b0;
  assign SDA_out   = 1'b0;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      quarter  <= 2'd0;
      div      <= '0;
      sh       <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      SCL_ena  <= 1'b0;
      SDA_ena  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ena) begin
        if (state == ST_IDLE) begin
          SCL_ena <= 1'b0;
          SDA_ena <= 1'b0;
          if (start) begin
            sh       <= {SLAVE_ADDR, 1'b0, REG_BASE, 2'b00, K_p, 2'b00, K_i, 2'b00, K_d};
            byte_idx <= 3'd0;
            bit_idx  <= 3'd0;
            ack_err  <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_START;
            quarter  <= 2'd0;
            div      <= '0;
          end
        end else begin
          if (state == ST_ACK && quarter == 2'd3 && div == '0 && SDA_in)
            ack_err <= 1'b1;
          if (!div_end) begin
            div <= div + 1'b1;
          end else if (q_end) begin
            div     <= '0;
            quarter <= quarter + 2'd1;
            // Line registers are loaded as a quarter ends so they hold for the next one.
            case (state)
              ST_START: begin
                if (quarter == 2'd1) SDA_ena <= 1'b1;
                if (quarter == 2'd3) begin
                  SCL_ena <= 1'b1;
                  SDA_ena <= ~sh[39];
                  state   <= ST_SHIFT;
                end
              end
              ST_SHIFT: begin
                if (quarter == 2'd1) SCL_ena <= 1'b0;
                if (quarter == 2'd3) begin
                  SCL_ena <= 1'b1;
                  sh      <= {sh[38:0], 1'b0};
                  if (bit_idx == 3'd7) begin
                    bit_idx <= 3'd0;
                    SDA_ena <= 1'b0;
                    state   <= ST_ACK;
                  end else begin
                    bit_idx <= bit_idx + 3'd1;
                    SDA_ena <= ~sh[38];
                  end
                end
              end
              ST_ACK: begin
                if (quarter == 2'd1) SCL_ena <= 1'b0;
                if (quarter == 2'd3) begin
                  SCL_ena <= 1'b1;
                  if (ack_err || byte_idx == 3'd4) begin
                    SDA_ena <= 1'b1;
                    state   <= ST_STOP;
                  end else begin
                    byte_idx <= byte_idx + 3'd1;
                    SDA_ena  <= ~sh[39];
                    state    <= ST_SHIFT;
                  end
                end
              end
              ST_STOP: begin
                if (quarter == 2'd0) SCL_ena <= 1'b0;
                if (quarter == 2'd1) SDA_ena <= 1'b0;
                if (quarter == 2'd3) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_gain_writer.sv
// Bench for i2c_gain_writer: an open-drain bus model with a slave that decodes
// bytes, ACKs/NACKs and stretches SCL, checked against a transaction-level model.
module tb_i2c_gain_writer;

  localparam int         CLK_DIV    = 4;
  localparam logic [6:0] SLAVE_ADDR = 7'h42;
  localparam logic [7:0] REG_BASE   = 8'h00;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic [5:0] K_p = 6'd0, K_i = 6'd0, K_d = 6'd0;
  logic       SCL_in, SCL_out, SCL_ena, SDA_in, SDA_out, SDA_ena;
  logic       busy, done, ack_err;
  logic [2:0] dbg_state;
  logic       scl_hold = 1'b0;
  logic       sda_hold = 1'b0;

  assign SCL_in = !SCL_ena && !scl_hold;
  assign SDA_in = !SDA_ena && !sda_hold;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_gain_writer #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(SLAVE_ADDR), .REG_BASE(REG_BASE)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start),
    .K_p(K_p), .K_i(K_i), .K_d(K_d),
    .SCL_in(SCL_in), .SCL_out(SCL_out), .SCL_ena(SCL_ena),
    .SDA_in(SDA_in), .SDA_out(SDA_out), .SDA_ena(SDA_ena),
    .busy(busy), .done(done), .ack_err(ack_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  // ---------------- bus / slave model ----------------
  int nack_byte = 5;     // byte index the slave refuses; 5 = ACK everything
  int stretch_rel = -1;  // bit slot (counted by SCL releases) to stretch
  int stretch_h = 0;     // cycles SCL is held low from its release
  int rise_cnt = 0, rel_cnt = 0, start_cnt = 0, stop_cnt = 0, hold_cnt = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_scl_ena = 1'b0;
  logic scl_l, sda_l;
  logic [7:0] cur = 8'd0;

  always @(negedge clk) begin
    if (rst) begin
      scl_hold     = 1'b0;
      sda_hold     = 1'b0;
      hold_cnt     = 0;
      prev_scl_ena = 1'b0;
      prev_scl     = 1'b1;
      prev_sda     = 1'b1;
    end else begin
      if (scl_hold) begin
        hold_cnt--;
        if (hold_cnt == 0) scl_hold = 1'b0;
      end
      if (prev_scl_ena && !SCL_ena) begin
        if (rel_cnt == stretch_rel && stretch_h > 0) begin
          scl_hold = 1'b1;
          hold_cnt = stretch_h;
        end
        rel_cnt++;
      end
      scl_l = !SCL_ena && !scl_hold;
      sda_l = !SDA_ena && !sda_hold;
      if (prev_scl && scl_l && prev_sda && !sda_l) begin
        start_cnt++;
        rise_cnt = 0;
        rel_cnt  = 0;
      end else if (prev_scl && scl_l && !prev_sda && sda_l) begin
        stop_cnt++;
      end
      if (!prev_scl && scl_l) begin
        rise_cnt++;
        if (rise_cnt % 9 != 0) begin
          cur = {cur[6:0], sda_l};
          if (rise_cnt % 9 == 8) got_q.push_back(cur);
        end
      end
      if (prev_scl && !scl_l && rise_cnt > 0) begin
        if (rise_cnt % 9 == 8 && (rise_cnt / 9) != nack_byte) sda_hold = 1'b1;
        else if (rise_cnt % 9 == 0) sda_hold = 1'b0;
      end
      prev_scl_ena = SCL_ena;
      prev_scl     = !SCL_ena && !scl_hold;
      prev_sda     = !SDA_ena && !sda_hold;
    end
  end

  // ---------------- reference model ----------------
  function automatic int sent_bytes(input int nack);
    return (nack < 5) ? nack + 1 : 5;
  endfunction

  function automatic int ref_delay(input int nack, input int s, input int gap);
    return 4 * CLK_DIV * (2 + 9 * sent_bytes(nack)) + s + gap;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic configure(input int nack, input int rel, input int s);
    nack_byte   = nack;
    stretch_rel = rel;
    stretch_h   = (s > 0) ? s + CLK_DIV - 1 : 0;
  endtask

  task automatic start_txn(input logic [5:0] kp, ki, kd, input int nack,
                           output int n, output int base);
    logic [7:0] all_b[5];
    all_b[0] = {SLAVE_ADDR, 1'b0};
    all_b[1] = REG_BASE;
    all_b[2] = {2'b00, kp};
    all_b[3] = {2'b00, ki};
    all_b[4] = {2'b00, kd};
    exp_q.delete();
    for (int i = 0; i < sent_bytes(nack); i++) exp_q.push_back(all_b[i]);
    base = got_q.size();
    @(negedge clk);
    K_p = kp; K_i = ki; K_d = kd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = cyc;
    check("busy_after_accept", busy, 1);
    check("ack_err_cleared_on_accept", ack_err, 0);
  endtask

  task automatic finish_txn(input string tag, input int n, input int base,
                            input int exp_delay, input logic exp_err);
    int d = -1;
    int ng;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        d = cyc - n;
        break;
      end
    end
    check({tag, "_done_seen"}, (d >= 0), 1);
    check({tag, "_done_delay"}, d, exp_delay);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_ack_err"}, ack_err, exp_err);
    ng = got_q.size() - base;
    check({tag, "_nbytes"}, ng, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ng; i++)
      check({tag, "_byte"}, got_q[base + i], exp_q[i]);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_ack_err_sticky"}, ack_err, exp_err);
  endtask

  task automatic run_txn(input string tag, input logic [5:0] kp, ki, kd,
                         input int nack, input int rel, input int s,
                         input int exp_delay, input logic exp_err);
    int n, base;
    configure(nack, rel, s);
    start_txn(kp, ki, kd, nack, n, base);
    finish_txn(tag, n, base, exp_delay, exp_err);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [5:0] kp, ki, kd;
    int         nack;
    int         rel;
    int         s;
    int         exp_delay;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, base, sc0, gap_s0, gap_d0;
    logic held;
    logic [5:0] kp, ki, kd;
    int nk, nb, s, rel;

    vecs[0] = '{6'h15, 6'h2A, 6'h3F, 5, -1, 0, 752, 1'b0};
    vecs[1] = '{6'h01, 6'h02, 6'h03, 0, -1, 0, 176, 1'b1};
    vecs[2] = '{6'h15, 6'h2A, 6'h3F, 5, 12, 10, 762, 1'b0};
    vecs[3] = '{6'h3F, 6'h00, 6'h2A, 2, -1, 0, 464, 1'b1};
    vecs[4] = '{6'h00, 6'h3F, 6'h15, 4, -1, 0, 752, 1'b1};
    vecs[5] = '{6'h2A, 6'h15, 6'h00, 5, 8, 5, 757, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_scl_ena", SCL_ena, 0);
    check("rst_sda_ena", SDA_ena, 0);
    check("rst_scl_out", SCL_out, 0);
    check("rst_sda_out", SDA_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven vectors
    for (int v = 0; v < 6; v++)
      run_txn($sformatf("vec%0d", v), vecs[v].kp, vecs[v].ki, vecs[v].kd,
              vecs[v].nack, vecs[v].rel, vecs[v].s, vecs[v].exp_delay, vecs[v].exp_err);

    // Randomized transactions against the model
    for (int r = 0; r < 6; r++) begin
      kp = 6'($urandom_range(0, 63));
      ki = 6'($urandom_range(0, 63));
      kd = 6'($urandom_range(0, 63));
      nk = $urandom_range(0, 5);
      nb = sent_bytes(nk);
      s  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
      rel = $urandom_range(0, 9 * nb - 1);
      run_txn($sformatf("rnd%0d", r), kp, ki, kd, nk, rel, s,
              ref_delay(nk, s, 0), (nk < 5));
    end

    // Gains toggled and start re-pulsed while busy
    configure(5, -1, 0);
    sc0 = start_cnt;
    start_txn(6'h15, 6'h2A, 6'h3F, 5, n, base);
    repeat (200) @(negedge clk);
    K_p = 6'h2A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    K_p = 6'h00;
    finish_txn("busy_poke", n, base, ref_delay(5, 0, 0), 1'b0);
    repeat (100) @(negedge clk);
    check("busy_poke_no_second_busy", busy, 0);
    check("busy_poke_start_count", start_cnt - sc0, 1);

    // ena low for 20 cycles mid-byte
    configure(5, -1, 0);
    start_txn(6'h0F, 6'h30, 6'h21, 5, n, base);
    repeat (300) @(negedge clk);
    gap_s0 = int'(SCL_ena);
    gap_d0 = int'(SDA_ena);
    ena = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (int'(SCL_ena) != gap_s0 || int'(SDA_ena) != gap_d0) held = 1'b0;
    end
    ena = 1'b1;
    check("ena_gap_lines_held", held, 1);
    finish_txn("ena_gap", n, base, ref_delay(5, 0, 20), 1'b0);

    // Reset during byte 2, then a fresh transaction
    configure(5, -1, 0);
    start_txn(6'h11, 6'h22, 6'h33, 5, n, base);
    repeat (340) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_scl_ena", SCL_ena, 0);
    check("midrst_sda_ena", SDA_ena, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_txn("after_rst", 6'h15, 6'h2A, 6'h3F, 5, -1, 0, 752, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
